// File: rtl/comm_rx.sv
// comm_rx: UART-framed receiver assembling four bytes into a 32-bit word with a level interrupt/ack handshake
// Ports: sys_clk, rst_n (async active-low), rx_in (async serial, idle high), int_ack (processor ack);
//        interrupt_eth (word pending), interrupt_source_data (word), rx_overrun (sticky drop flag),
//        rx_frame_err (one-cycle bad stop/parity pulse).
// Macro COMM_RX_PARITY_EN adds an even-parity bit after bit 7 (11-bit frame); undefined gives 8N1.
module comm_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        rx_in,
  input  logic        int_ack,
  output logic        interrupt_eth,
  output logic [31:0] interrupt_source_data,
  output logic        rx_overrun,
  output logic        rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_BITS);
`ifdef COMM_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q, state_d;
  logic [2:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          eth_q, eth_d, ovr_q, ovr_d, ferr_q, ferr_d;
  logic [31:0]   data_q, data_d;
  logic          rx, fall, tick, ok;
  // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection
  assign rx   = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = cnt_q == LAST;
`ifdef COMM_RX_PARITY_EN
  logic perr_q, perr_d;
  assign ok = rx & ~perr_q;
`else
  assign ok = rx;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    tmo_d   = '0;
    eth_d   = eth_q & ~int_ack;
    ovr_d   = ovr_q & ~(eth_q & int_ack);
    data_d  = data_q;
    ferr_d  = 1'b0;
`ifdef COMM_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        // bit-time counting between bytes of a partial word; saturating
        tmo_d = (idx_q == 2'd0) ? '0 : (tick && tmo_q != TMAX) ? tmo_q + 1'b1 : tmo_q;
        if (tmo_q == TMAX) idx_d = 2'd0;
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bit_d   = 3'd0;
        state_d = rx ? IDLE : DATA;
      end
      DATA: if (tick) begin
        sh_d  = {rx, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
`ifdef COMM_RX_PARITY_EN
        if (&bit_q) state_d = PARITY;
`else
        if (&bit_q) state_d = STOP;
`endif
      end
`ifdef COMM_RX_PARITY_EN
      PARITY: if (tick) begin
        perr_d  = rx ^ (^sh_q);
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        if (ok) begin
          idx_d = idx_q + 1'b1;
          asm_d = {sh_q, asm_q[23:8]};
          // ack in the completing cycle frees the slot for the new word
          if (&idx_q) begin
            if (!eth_q || int_ack) begin
              data_d = {sh_q, asm_q};
              eth_d  = 1'b1;
            end else ovr_d = 1'b1;
          end
        end else begin
          ferr_d = 1'b1;
          idx_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      tmo_q   <= '0;
      eth_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
`ifdef COMM_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[1:0], rx_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
      eth_q   <= eth_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
`ifdef COMM_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end
  assign interrupt_eth         = eth_q;
  assign interrupt_source_data = data_q;
  assign rx_overrun            = ovr_q;
  assign rx_frame_err          = ferr_q;
endmodule

// File: doc/comm_rx.md
# comm_rx

Serial receive end of the inter-board game link. Deserialises four UART-framed bytes from the opponent's board into one 32-bit word. Presents the word to the processor as `interrupt_source_data` with a level `interrupt_eth` request, which is held until acknowledged. This block is the receive counterpart of the word the processor latches for transmission on `snd`.

## Interface
- `CLKS_PER_BIT`, 434: `sys_clk` cycles per serial bit (50 MHz / 115200). Minimum 4.
- `TIMEOUT_BITS`, 32: maximum idle bit-times allowed between bytes of one word.
- `sys_clk`  input  1  system clock; all logic on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `rx_in`  input  1  serial line, asynchronous, idle high.
- `int_ack`  input  1  processor acknowledge for the pending word.
- `interrupt_eth`  output  1  word-pending request (level).
- `interrupt_source_data`  output  32  received word.
- `rx_overrun`  output  1  sticky: a word was dropped because one was already pending.
- `rx_frame_err`  output  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).

## Operation
- Reset values: `interrupt_eth`=0, `interrupt_source_data`=0, `rx_overrun`=0, `rx_frame_err`=0. FSM is in IDLE, byte index is 0, and synchroniser flops are 1.
- `rx_in` passes through a 2-flop synchroniser. All further references are to the synchronised signal.
- FSM states:
  - IDLE: a falling edge starts the bit counter and moves to START.
  - START: at `CLKS_PER_BIT/2` sample the line. Low moves to DATA. High is treated as a glitch and returns to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - PARITY: present only with the macro enabled.
  - STOP: sample one bit later. High completes the byte. Low pulses `rx_frame_err` and discards the byte and the whole partial word (byte index goes to 0). Either way, return to IDLE.
- Word assembly: byte 0 goes to bits [7:0] and byte 3 to bits [31:24].
- Inter-byte timeout: in IDLE with byte index ≠ 0, count bit-times. Reaching `TIMEOUT_BITS` silently discards the partial word (byte index goes to 0, no error pulse).
- Word delivery, on completing byte 3:
  - `interrupt_eth`=0, or `int_ack`=1 in the same cycle: load `interrupt_source_data` and set `interrupt_eth`=1.
  - Otherwise: keep the old word and set `rx_overrun`=1.
- Handshake:
  - `int_ack`=1 while `interrupt_eth`=1 clears `interrupt_eth` and `rx_overrun` on the next edge.
  - `int_ack` while not pending has no effect.
  - A simultaneous ack and new word leaves `interrupt_eth`=1 with the new data.
- `interrupt_source_data` holds its value after ack until the next delivered word.
- Asserting `rst_n` mid-frame aborts immediately. After release, reception resynchronises on the next falling edge from IDLE.

## Timing
- Synchroniser latency: 2 cycles.
- Start-bit sample: `CLKS_PER_BIT/2` cycles after the detected edge.
- Data sample *k* (0..7): `(k+1)·CLKS_PER_BIT` cycles after the start-bit sample.
- `interrupt_eth` rises 1 cycle after the byte-3 stop-bit sample cycle.
- `rx_frame_err` is high exactly one cycle, registered the cycle after the failing sample.
- A new start edge is accepted from the cycle after the stop-bit sample. This leaves ½-bit margin for back-to-back bytes.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. Timeout counter width is `$clog2(TIMEOUT_BITS+1)`. There is no wrap: the timeout counter saturates at `TIMEOUT_BITS`.

## Configuration
- `COMM_RX_PARITY_EN` defined:
  - Each byte carries an even-parity bit after bit 7, sampled one bit-time after bit 7. The frame is 11 bits.
  - A parity mismatch is handled like a bad stop bit: `rx_frame_err` pulse and partial word discarded. The stop bit is still waited for before returning to IDLE.
- Not defined: there is no PARITY state, and the frame is 10 bits (8N1).

## Test plan
- Word delivery (`CLKS_PER_BIT`=4): send bytes EF, BE, AD, DE back to back → `interrupt_source_data`=32'hDEADBEEF, `interrupt_eth`=1 one cycle after the last stop sample. `int_ack` pulse → `interrupt_eth`=0 on the next edge, data held.
- Overrun: two full words 32'h00000001 then 32'h00000002 with no ack → data stays 32'h00000001 and `rx_overrun`=1. Ack → both clear.
- Simultaneous ack: ack asserted in the exact cycle word 32'h12345678 completes over pending 32'hA5A5A5A5 → next cycle `interrupt_eth`=1 and data=32'h12345678.
- Error and glitch:
  - A stop bit driven low on byte 1 → one-cycle `rx_frame_err`. Then a clean word 32'hCAFEF00D → received correctly, with no stale bytes.
  - A 1-cycle low glitch → no error and no state change.
- Timeout: send 2 bytes, idle `TIMEOUT_BITS`+1 bit-times, then send 4 bytes 11 22 33 44 → data=32'h44332211.
- Reset and parity:
  - `rst_n` low mid-byte-2 → all outputs 0. Then a full word is received correctly.
  - With `COMM_RX_PARITY_EN`, a corrupted parity bit → `rx_frame_err` pulse and no `interrupt_eth`.
